// File: rtl/swervolf_sevenseg.sv
// Four-digit multiplexed seven-segment driver for the Basys3 SweRVolf top level.
// The value is captured into shadow registers once per scan frame, so digits never tear.
module swervolf_sevenseg #(
    parameter int DIGIT_CYCLES = 25000,
    parameter int BLANK_CYCLES = 250
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] i_value,
    input  logic [3:0]  i_en,
    input  logic [3:0]  i_dp,
    output logic [3:0]  o_an,
    output logic [6:0]  o_seg,
    output logic        o_dp,
    output logic        o_frame
);

    localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX   = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

    logic [CW-1:0] cnt_reg;
    logic [1:0]    idx_reg;
    logic [15:0]   sh_value_reg;
    logic [3:0]    sh_en_reg;
    logic [3:0]    sh_dp_reg;
    logic [3:0]    an_reg;
    logic [6:0]    seg_reg;
    logic          dp_reg;
    logic          frame_reg;

    logic          load;
    logic          blank;
    logic [3:0]    nibble;
    logic [3:0]    an_next;
    logic [6:0]    seg_next;
    logic          dp_next;

    // Active-low gfedcba pattern for one hex nibble.
    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    assign load  = (cnt_reg == '0) && (idx_reg == 2'd0);
    assign blank = (cnt_reg < BLANK_END);

    always_comb begin
        nibble   = sh_value_reg[idx_reg*4 +: 4];
        seg_next = hex7(nibble);
        an_next  = 4'hF;
        dp_next  = ~(sh_dp_reg[idx_reg] & sh_en_reg[idx_reg]);
        if (sh_en_reg[idx_reg])
            an_next = ~(4'b0001 << idx_reg);
        // Blanking at slot start keeps anode hand-overs from ghosting.
        if (blank) begin
            an_next  = 4'hF;
            seg_next = 7'h7F;
            dp_next  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
            idx_reg <= 2'd0;
        end else if (cnt_reg == CNT_MAX) begin
            cnt_reg <= '0;
            idx_reg <= idx_reg + 2'd1;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_value_reg <= 16'h0000;
            sh_en_reg    <= 4'h0;
            sh_dp_reg    <= 4'h0;
            frame_reg    <= 1'b0;
        end else begin
            frame_reg <= load;
            if (load) begin
                sh_value_reg <= i_value;
                sh_en_reg    <= i_en;
                sh_dp_reg    <= i_dp;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_reg  <= 4'hF;
            seg_reg <= 7'h7F;
            dp_reg  <= 1'b1;
        end else begin
            an_reg  <= an_next;
            seg_reg <= seg_next;
            dp_reg  <= dp_next;
        end
    end

    assign o_an    = an_reg;
    assign o_seg   = seg_reg;
    assign o_dp    = dp_reg;
    assign o_frame = frame_reg;

endmodule

// File: tb/tb_swervolf_sevenseg.sv
// Bench for swervolf_sevenseg: a frame-level model checked every cycle plus
// hand-computed literal expectations for the directed scenarios.
module tb_swervolf_sevenseg;

    localparam int DC = 8;
    localparam int BC = 2;
    localparam int FR = 4 * DC;

    logic        clk;
    logic        rst;
    logic [15:0] i_value;
    logic [3:0]  i_en;
    logic [3:0]  i_dp;
    logic [3:0]  o_an;
    logic [6:0]  o_seg;
    logic        o_dp;
    logic        o_frame;

    int checks = 0;
    int errors = 0;
    int c = 0;
    bit cmp_en = 0;

    swervolf_sevenseg #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(BC)) dut (
        .clk(clk), .rst(rst), .i_value(i_value), .i_en(i_en), .i_dp(i_dp),
        .o_an(o_an), .o_seg(o_seg), .o_dp(o_dp), .o_frame(o_frame)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    logic [6:0] hex_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Model: n counts clock edges since reset release; each frame is FR edges.
    int          n;
    logic [15:0] m_val;
    logic [3:0]  m_en, m_dpi;
    logic [3:0]  m_an;
    logic [6:0]  m_seg;
    logic        m_dp, m_frame;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            n <= 0; m_val <= 0; m_en <= 0; m_dpi <= 0;
            m_an <= 4'hF; m_seg <= 7'h7F; m_dp <= 1'b1; m_frame <= 1'b0;
        end else begin
            m_frame <= (n % FR == 0);
            if (n % FR == 0) begin
                m_val <= i_value; m_en <= i_en; m_dpi <= i_dp;
            end
            if (n % DC < BC) begin
                m_an <= 4'hF; m_seg <= 7'h7F; m_dp <= 1'b1;
            end else begin
                m_an  <= m_en[(n / DC) % 4] ? ~(4'd1 << ((n / DC) % 4)) : 4'hF;
                m_seg <= hex_tab[(m_val >> (4 * ((n / DC) % 4))) & 16'hF];
                m_dp  <= ~(m_dpi[(n / DC) % 4] & m_en[(n / DC) % 4]);
            end
            n <= n + 1;
        end
    end

    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            checks++;
            if ({o_an, o_seg, o_dp, o_frame} !== {m_an, m_seg, m_dp, m_frame}) begin
                errors++;
                $display("FAIL model c=%0d got an=%b seg=%b dp=%b fr=%b want an=%b seg=%b dp=%b fr=%b",
                         c, o_an, o_seg, o_dp, o_frame, m_an, m_seg, m_dp, m_frame);
            end
            checks++;
            if ($countones(~o_an) > 1) begin
                errors++;
                $display("FAIL onehot c=%0d got an=%b want at most one low", c, o_an);
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s c=%0d got %h want %h", name, c, act, exp);
        end else begin
            $display("ok   %s c=%0d value %h", name, c, act);
        end
    endtask

    // c is the number of negedges since release; outputs then reflect edge c-1.
    task automatic step_to(input int t);
        while (c < t) begin
            @(negedge clk);
            c++;
        end
    endtask

    initial begin
        rst = 1; i_value = 16'h1234; i_en = 4'hF; i_dp = 4'h0;
        repeat (3) @(negedge clk);
        chk("rst_an", {12'h0, o_an}, 16'h000F);
        chk("rst_seg", {9'h0, o_seg}, 16'h007F);
        chk("rst_dpfr", {14'h0, o_dp, o_frame}, 16'h0002);
        rst = 0; c = 0; cmp_en = 1;

        step_to(1);  chk("frame_first", {15'h0, o_frame}, 16'h1);
        step_to(2);  chk("frame_drop", {15'h0, o_frame}, 16'h0);
                     chk("blank_an", {12'h0, o_an}, 16'h000F);
        step_to(3);  chk("d0_an", {12'h0, o_an}, 16'h000E);
                     chk("d0_seg", {9'h0, o_seg}, {9'h0, 7'b0011001});
        step_to(11); chk("d1_an", {12'h0, o_an}, 16'h000D);
                     chk("d1_seg", {9'h0, o_seg}, {9'h0, 7'b0110000});
        step_to(19); chk("d2_seg", {9'h0, o_seg}, {9'h0, 7'b0100100});
        step_to(27); chk("d3_an", {12'h0, o_an}, 16'h0007);
                     chk("d3_seg", {9'h0, o_seg}, {9'h0, 7'b1111001});

        // Asynchronous reset while digit 0 is lit
        for (int i = 0; i < 64 && o_an !== 4'b1110; i++) step_to(c + 1);
        chk("find_1110", {12'h0, o_an}, 16'h000E);
        #2 rst = 1;
        #1;
        chk("mid_rst_an", {12'h0, o_an}, 16'h000F);
        chk("mid_rst_seg", {9'h0, o_seg}, 16'h007F);
        chk("mid_rst_dpfr", {14'h0, o_dp, o_frame}, 16'h0002);
        @(negedge clk);
        @(negedge clk);
        rst = 0; c = 0;

        step_to(1);  chk("rel_frame", {15'h0, o_frame}, 16'h1);
        step_to(2);  chk("rel_frame_low", {15'h0, o_frame}, 16'h0);
        step_to(13); i_value = 16'hABCD;
        step_to(21); chk("hold_d2_an", {12'h0, o_an}, 16'h000B);
                     chk("hold_d2_seg", {9'h0, o_seg}, {9'h0, 7'b0100100});
        step_to(29); chk("hold_d3_seg", {9'h0, o_seg}, {9'h0, 7'b1111001});
        step_to(33); chk("frame_period", {15'h0, o_frame}, 16'h1);
        step_to(35); chk("new_d0_an", {12'h0, o_an}, 16'h000E);
                     chk("new_d0_seg", {9'h0, o_seg}, {9'h0, 7'b0100001});

        // Digit enables 0101
        i_en = 4'b0101;
        step_to(67); chk("en_d0_an", {12'h0, o_an}, 16'h000E);
        step_to(76); chk("en_d1_off", {12'h0, o_an}, 16'h000F);
        step_to(84); chk("en_d2_an", {12'h0, o_an}, 16'h000B);
        step_to(92); chk("en_d3_off", {12'h0, o_an}, 16'h000F);

        // Decimal point on digit 3
        i_en = 4'hF; i_dp = 4'b1000;
        step_to(99);  chk("dp_d0_off", {15'h0, o_dp}, 16'h1);
        step_to(124); chk("dp_d3_an", {12'h0, o_an}, 16'h0007);
                      chk("dp_d3_on", {15'h0, o_dp}, 16'h0);
        i_en = 4'b0111;
        step_to(156); chk("dp_dis_an", {12'h0, o_an}, 16'h000F);
                      chk("dp_dis", {15'h0, o_dp}, 16'h1);

        // Decode sweep over digit 0
        i_en = 4'hF; i_dp = 4'h0;
        for (int x = 0; x < 16; x++) begin
            step_to(160 + FR * x);
            i_value = 16'(x);
            step_to(163 + FR * x);
            if (x == 0)  chk("dec_0", {9'h0, o_seg}, {9'h0, 7'b1000000});
            if (x == 8)  chk("dec_8", {9'h0, o_seg}, {9'h0, 7'b0000000});
            if (x == 15) chk("dec_F", {9'h0, o_seg}, {9'h0, 7'b0001110});
            step_to(171 + FR * x);
            if (x == 15) chk("dec_d1_zero", {9'h0, o_seg}, {9'h0, 7'b1000000});
        end
        step_to(c + 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/swervolf_sevenseg.md
Name: swervolf_sevenseg

Overview:
Four-digit, time-multiplexed seven-segment display driver for the Basys3 SweRVolf top level. It sits directly downstream of the core's GPIO output and consumes a 16-bit hex value, per-digit enables and decimal points. It drives the board's shared active-low segment lines and per-digit active-low anodes. The displayed value is latched once per scan frame, so software updates never tear across digits.

Parameters:
DIGIT_CYCLES, 25000, clk cycles each digit slot lasts (1 ms at 25 MHz); legal range 2..2^20.
BLANK_CYCLES, 250, cycles at the start of each slot with all anodes off (anti-ghosting); legal range 1..DIGIT_CYCLES-1.

Ports:
clk  in  1  core clock (clk_core domain)
rst  in  1  asynchronous, active-high reset
i_value  in  16  hex value; digit n displays i_value[4n+3:4n]; digit 0 is rightmost
i_en  in  4  per-digit enable; 0 keeps that anode off for its slot
i_dp  in  4  per-digit decimal point, 1 = lit
o_an  out  4  anodes, active-low; o_an[n] selects digit n
o_seg  out  7  segments {g,f,e,d,c,b,a}, active-low
o_dp  out  1  decimal point, active-low
o_frame  out  1  one-cycle pulse marking a shadow-register load

Behaviour:
- Single clock domain: clk, with rst asynchronous and active-high. All inputs are synchronous to clk, and no input synchronisers are included.
- Slot counter cnt, width clog2(DIGIT_CYCLES):
  - counts 0..DIGIT_CYCLES-1, then wraps to 0;
  - on wrap, 2-bit digit index idx increments, 3 wraps to 0.
- Shadow load: on any cycle with cnt==0 and idx==0:
  - sh_value<=i_value, sh_en<=i_en, sh_dp<=i_dp;
  - o_frame<=1 (registered, so visible the following cycle);
  - o_frame<=0 in all other cycles.
  - The frame period is 4*DIGIT_CYCLES cycles, and o_frame is high exactly one cycle per frame.
- Output registration: o_an, o_seg and o_dp are registered from (cnt, idx, shadow) of the previous cycle, giving 1-cycle latency.
- Slot timing:
  - cnt < BLANK_CYCLES: o_an<=4'hF, o_seg<=7'h7F, o_dp<=1.
  - otherwise: o_an<=~(sh_en[idx] << idx), o_seg<=hex7(sh_value nibble idx), o_dp<=~(sh_dp[idx] & sh_en[idx]).
  - A disabled digit gives o_an=4'hF, with o_seg/o_dp don't-care but must still follow the decode.
- Hex decode (active-low gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Input changes while a frame is in progress are ignored until the next load. A change on the exact cycle of a load is captured.
- At most one anode is low in any cycle. Anode transitions always pass through at least BLANK_CYCLES cycles of 4'hF.
- Reset, asynchronous, any cycle including mid-slot:
  - cnt=0, idx=0, sh_*=0, o_an=4'hF, o_seg=7'h7F, o_dp=1, o_frame=0.
  - In the first cycle after deassertion a shadow load occurs (cnt==0, idx==0), and o_frame pulses in the second cycle.
- No other state; no handshake. Inputs are sampled only at frame load.

Test Plan:
(Bench parameters: DIGIT_CYCLES=8, BLANK_CYCLES=2; frame = 32 cycles.)
1. Assert rst mid-slot while o_an=4'b1110 -> same-cycle o_an=4'hF, o_seg=7'h7F, o_dp=1, o_frame=0. Release -> o_frame pulses at cycle 2 after release, then every 32 cycles.
2. i_value=16'h1234, i_en=4'hF, i_dp=0 -> repeating pattern of 2 cycles 4'hF followed by:
   - 6 cycles o_an=1110 with o_seg=0011001;
   - 2 blank, then 6 cycles 1101 with 0110000;
   - 2 blank, then 6 cycles 1011 with 0100100;
   - 2 blank, then 6 cycles 0111 with 1111001.
3. Change i_value 1234->ABCD while digit 1 is lit -> digits 1-3 keep showing 3,2,1 for the rest of the frame. ABCD appears starting from the next frame's digit 0 (o_seg=0100001).
4. i_en=4'b0101 -> o_an never has bit 1 or bit 3 low. Digits 0/2 keep their original slot timing, and slots 1/3 show 4'hF for all 8 cycles.
5. i_dp=4'b1000, i_en=4'hF -> o_dp=0 only while o_an=0111, else 1. With i_en=4'b0111, o_dp stays 1 for the whole frame.
6. Sweep i_value=16'h000X for X=0..F over 16 frames -> digit-0 o_seg matches the decode table (0->1000000, 8->0000000, F->0001110). Digits 1-3 show 1000000.
